spiker_step_sequencer: RTL

// - Sequences one inference of the spiker core over a programmable number of time steps.
// - Starts the core, waits for per-step ready, then issues one sample pulse per step to the result writer.
// - Signals done after the last step.
// - Sits between the spiker_adapter register file (start/abort/step count), the spiker core and the result writer.

---
 rtl/spiker_adapter_reg_pkg.sv | 25 ++
 rtl/spiker_step_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spiker_adapter_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spiker_adapter_reg_pkg
// Description : Shared types and constants for the spiker adapter register
//               file and its step sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package spiker_adapter_reg_pkg;

    // Step count used when software programs 0 or an out-of-range value
    localparam int N_STEPS_DEFAULT = 15;

    // Step sequencer state encoding (SEQ_ERR is reachable only with the watchdog)
    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_LAUNCH   = 3'd1,
        SEQ_WAIT_RDY = 3'd2,
        SEQ_SAMPLE   = 3'd3,
        SEQ_HOLD     = 3'd4,
        SEQ_DONE     = 3'd5,
        SEQ_ERR      = 3'd6
    } seq_state_e;

endpackage : spiker_adapter_reg_pkg
`default_nettype wire

// File: rtl/spiker_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spiker_step_sequencer
// Description : Runs one spiker inference over a programmable number of time
//               steps: launches the core, waits for each step to complete,
//               strobes the result writer once per step and flags done.
//               Optional watchdog enabled by defining SPIKER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spiker_step_sequencer
    import spiker_adapter_reg_pkg::*;
#(
    parameter int N_STEPS_MAX = N_STEPS_DEFAULT,
    parameter int CNT_W       = 4,
    parameter int TMO_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] n_steps_i,
    output logic             core_start_o,
    input  logic             core_ready_i,
    input  logic             writer_ready_i,
    output logic             sample_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] step_cnt_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] c_step_max = CNT_W'(N_STEPS_MAX);
    localparam logic [CNT_W-1:0] c_step_one = CNT_W'(1);

    seq_state_e       r_state;
    seq_state_e       w_state_next;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_step_cnt;
    logic             r_done;
    logic             r_err;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_target_new;
    logic             w_waiting;
    logic             w_tmo_hit;

    // Zero or oversized requests fall back to the largest supported count,
    // which also guarantees the step counter can never wrap.
    assign w_target_new = ((n_steps_i == '0) || (n_steps_i > c_step_max)) ? c_step_max : n_steps_i;
    assign w_cnt_inc    = r_step_cnt + c_step_one;
    assign w_waiting    = (r_state == SEQ_WAIT_RDY) || (r_state == SEQ_HOLD);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort overrides everything, including a pending start
    always_comb begin
        w_state_next = r_state;
        if (abort_i) begin
            w_state_next = SEQ_IDLE;
        end else begin
            case (r_state)
                SEQ_IDLE: begin
                    if (start_i) begin
                        w_state_next = SEQ_LAUNCH;
                    end
                end
                SEQ_LAUNCH: begin
                    w_state_next = SEQ_WAIT_RDY;
                end
                SEQ_WAIT_RDY: begin
                    if (core_ready_i && writer_ready_i) begin
                        w_state_next = SEQ_SAMPLE;
                    end else if (w_tmo_hit) begin
                        w_state_next = SEQ_ERR;
                    end
                end
                SEQ_SAMPLE: begin
                    w_state_next = (w_cnt_inc == r_target) ? SEQ_DONE : SEQ_HOLD;
                end
                SEQ_HOLD: begin
                    // Core must drop ready before the next step can be sampled
                    if (!core_ready_i) begin
                        w_state_next = SEQ_WAIT_RDY;
                    end else if (w_tmo_hit) begin
                        w_state_next = SEQ_ERR;
                    end
                end
                SEQ_DONE: begin
                    w_state_next = SEQ_IDLE;
                end
                SEQ_ERR: begin
                    w_state_next = SEQ_IDLE;
                end
                default: begin
                    w_state_next = SEQ_IDLE;
                end
            endcase
        end
    end

    // Target, step counter and sticky status flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_target   <= '0;
            r_step_cnt <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else if (abort_i) begin
            // Counter stays frozen so software can see how far the run got
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                SEQ_IDLE: begin
                    if (start_i) begin
                        r_target   <= w_target_new;
                        r_step_cnt <= '0;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                    end
                end
                SEQ_SAMPLE: begin
                    r_step_cnt <= w_cnt_inc;
                    if (w_cnt_inc == r_target) begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
            if ((w_state_next == SEQ_ERR) && (r_state != SEQ_ERR)) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef SPIKER_TIMEOUT_EN
    generate
        if (1) begin : g_watchdog
            logic [TMO_W-1:0] r_tmo;

            // Watchdog restarts on every state change and counts while waiting
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_tmo <= '0;
                end else if (w_state_next != r_state) begin
                    r_tmo <= '0;
                end else if (w_waiting) begin
                    r_tmo <= r_tmo + TMO_W'(1);
                end
            end

            assign w_tmo_hit = w_waiting && (&r_tmo);
        end : g_watchdog
    endgenerate
`else
    // Watchdog compiled out: constant-false expression keeps TMO_W referenced
    assign w_tmo_hit = (TMO_W < 0) && w_waiting;
`endif

    assign core_start_o = (r_state == SEQ_LAUNCH);
    assign busy_o       = (r_state == SEQ_LAUNCH) || (r_state == SEQ_SAMPLE) || w_waiting;
    assign sample_o     = (r_state == SEQ_SAMPLE) && !abort_i;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign step_cnt_o   = r_step_cnt;

endmodule : spiker_step_sequencer
`default_nettype wire
